// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   Circular instruction buffer between fetch and decode/dispatch. It accepts
//   up to two instructions per cycle with their PC and prediction tags. It
//   presents the two oldest entries to the decoders and retires them as
//   dispatch consumes them. A flush discards all contents in one cycle.
//
// Ports
//   clock, reset_n            clock; asynchronous active-low reset
//   in_valid/in_ready         per-lane enqueue handshake (lane 0 older)
//   in_inst/in_pc/in_pred_*   enqueue payload, lane n at bits [n*W +: W]
//   out_valid                 head presentation (lane 0 = oldest)
//   out_inst/out_pc/out_pred_* head payload, lane n at bits [n*W +: W]
//   deq_count                 entries consumed this cycle (0..2)
//   flush                     discard all contents
//   count/full/empty          occupancy status
// -----------------------------------------------------------------------------
module inst_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2,
    parameter int INST  = 32,
    parameter int ADDR  = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in_valid,
    input  logic [WIDTH*INST-1:0]      in_inst,
    input  logic [WIDTH*ADDR-1:0]      in_pc,
    input  logic [WIDTH-1:0]           in_pred_taken,
    input  logic [WIDTH*ADDR-1:0]      in_pred_target,
    output logic [WIDTH-1:0]           in_ready,
    output logic [WIDTH-1:0]           out_valid,
    output logic [WIDTH*INST-1:0]      out_inst,
    output logic [WIDTH*ADDR-1:0]      out_pc,
    output logic [WIDTH-1:0]           out_pred_taken,
    output logic [WIDTH*ADDR-1:0]      out_pred_target,
    input  logic [1:0]                 deq_count,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [INST-1:0]  inst_mem_r   [DEPTH];
    logic [ADDR-1:0]  pc_mem_r     [DEPTH];
    logic             taken_mem_r  [DEPTH];
    logic [ADDR-1:0]  target_mem_r [DEPTH];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    logic [PTR_W-1:0] head_p1_s;
    logic [PTR_W-1:0] tail_p1_s;
    logic [1:0]       acc_s;
    logic [1:0]       acc_n_s;
    logic [1:0]       avail_s;
    logic [1:0]       deq_eff_s;
    logic [PTR_W-1:0] head_nxt_s;
    logic [PTR_W-1:0] tail_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;

    assign head_p1_s = head_r + PTR_W'(1);
    assign tail_p1_s = tail_r + PTR_W'(1);

    // Status and head presentation, driven only from registered state
    always_comb begin
        in_ready[0]  = (count_r <= CNT_W'(DEPTH - 1));
        in_ready[1]  = (count_r <= CNT_W'(DEPTH - 2));
        out_valid[0] = (count_r >= CNT_W'(1));
        out_valid[1] = (count_r >= CNT_W'(2));
        full         = (count_r == CNT_W'(DEPTH));
        empty        = (count_r == CNT_W'(0));
        count        = count_r;
        out_inst        = {inst_mem_r[head_p1_s],   inst_mem_r[head_r]};
        out_pc          = {pc_mem_r[head_p1_s],     pc_mem_r[head_r]};
        out_pred_taken  = {taken_mem_r[head_p1_s],  taken_mem_r[head_r]};
        out_pred_target = {target_mem_r[head_p1_s], target_mem_r[head_r]};
    end

    // Accept/dequeue decisions and next pointer/count values
    always_comb begin
        acc_s       = 2'b00;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        // A lane-1-only request is illegal and enqueues nothing; flush
        // overrides any enqueue in the same cycle.
        if (!flush && !(in_valid[1] && !in_valid[0])) begin
            acc_s = in_valid & in_ready;
        end else begin
            acc_s = 2'b00;
        end
        acc_n_s = {1'b0, acc_s[0]} + {1'b0, acc_s[1]};
        avail_s = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
        // Over-asking dispatch is clamped to what is actually presented.
        if (deq_count > avail_s) begin
            deq_eff_s = avail_s;
        end else begin
            deq_eff_s = deq_count;
        end
        if (flush) begin
            head_nxt_s  = {PTR_W{1'b0}};
            tail_nxt_s  = {PTR_W{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            head_nxt_s  = head_r + PTR_W'(deq_eff_s);
            tail_nxt_s  = tail_r + PTR_W'(acc_n_s);
            count_nxt_s = count_r + CNT_W'(acc_n_s) - CNT_W'(deq_eff_s);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Entry storage writes; contents are intentionally not reset
    always_ff @(posedge clock) begin
        if (acc_s[0]) begin
            inst_mem_r[tail_r]   <= in_inst[0 +: INST];
            pc_mem_r[tail_r]     <= in_pc[0 +: ADDR];
            taken_mem_r[tail_r]  <= in_pred_taken[0];
            target_mem_r[tail_r] <= in_pred_target[0 +: ADDR];
        end
        if (acc_s[1]) begin
            inst_mem_r[tail_p1_s]   <= in_inst[INST +: INST];
            pc_mem_r[tail_p1_s]     <= in_pc[ADDR +: ADDR];
            taken_mem_r[tail_p1_s]  <= in_pred_taken[1];
            target_mem_r[tail_p1_s] <= in_pred_target[ADDR +: ADDR];
        end
    end

    inst_buffer_chk u_chk (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid[1:0]),
        .out_valid (out_valid[1:0]),
        .deq_count (deq_count),
        .flush     (flush)
    );
endmodule

// -----------------------------------------------------------------------------
// inst_buffer_chk
//   Flags illegal handshakes: lane 1 valid without lane 0, and dispatch
//   consuming more entries than are presented.
// Ports: clock, reset_n, in_valid, out_valid, deq_count, flush (all inputs)
// -----------------------------------------------------------------------------
module inst_buffer_chk (
    input logic       clock,
    input logic       reset_n,
    input logic [1:0] in_valid,
    input logic [1:0] out_valid,
    input logic [1:0] deq_count,
    input logic       flush
);
    logic [1:0] avail_s;
    assign avail_s = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};

    // Protocol checks sampled at each rising edge outside reset
    always_ff @(posedge clock) begin
        if (reset_n) begin
            a_lane_order : assert (in_valid != 2'b10)
                else $error("inst_buffer: in_valid lane 1 without lane 0");
            a_deq_bound : assert (flush || (deq_count <= avail_s))
                else $error("inst_buffer: deq_count exceeds presented entries");
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  in_valid;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic [1:0]  in_pred_taken;
    logic [63:0] in_pred_target;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [1:0]  out_pred_taken;
    logic [63:0] out_pred_target;
    logic [1:0]  deq_count;
    logic        flush;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int tests = 0;
    int fails = 0;

    inst_buffer #(.DEPTH(8), .WIDTH(2), .INST(32), .ADDR(32)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_inst         (in_inst),
        .in_pc           (in_pc),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_pred_taken  (out_pred_taken),
        .out_pred_target (out_pred_target),
        .deq_count       (deq_count),
        .flush           (flush),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Payload derived from the PC so data lanes can be checked by formula
    task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [1:0] dq);
        logic [31:0] pc1;
        pc1            = pc0 + 32'd4;
        in_valid       = v;
        in_pc          = {pc1, pc0};
        in_inst        = {pc1 ^ 32'hA5A5_0000, pc0 ^ 32'hA5A5_0000};
        in_pred_taken  = {pc1[2], pc0[2]};
        in_pred_target = {pc1 + 32'h100, pc0 + 32'h100};
        deq_count      = dq;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int mcount, nxt, expd, cyc, en, want, rdy, acc, dq;
        logic [31:0] exp_pc;
        reset_n = 1'b0;
        flush   = 1'b0;
        drive(2'b00, 32'h0, 2'd0);
        #2;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd3);
        step();
        step();
        reset_n = 1'b1;

        // Two lanes per cycle, no dequeue
        drive(2'b11, 32'h0, 2'd0);
        step();
        chk("enq1_count", 64'(count), 64'd2);
        chk("enq1_pc0", 64'(out_pc[31:0]), 64'h0);
        chk("enq1_pc1", 64'(out_pc[63:32]), 64'h4);
        chk("enq1_inst0", 64'(out_inst[31:0]), 64'hA5A5_0000);
        chk("enq1_inst1", 64'(out_inst[63:32]), 64'hA5A5_0004);
        chk("enq1_taken", 64'(out_pred_taken), 64'b10);
        chk("enq1_tgt1", 64'(out_pred_target[63:32]), 64'h104);
        chk("enq1_out_valid", 64'(out_valid), 64'd3);
        drive(2'b11, 32'h8, 2'd0);
        step();
        chk("enq2_count", 64'(count), 64'd4);
        chk("enq2_pc0", 64'(out_pc[31:0]), 64'h0);

        // Fill to full
        drive(2'b11, 32'h10, 2'd0);
        step();
        drive(2'b11, 32'h18, 2'd0);
        step();
        chk("full_count", 64'(count), 64'd8);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);

        // Dequeue 2 while full: freed slots not credited this cycle
        drive(2'b11, 32'h20, 2'd2);
        #1;
        chk("full_deq_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("after_deq_count", 64'(count), 64'd6);
        chk("after_deq_in_ready", 64'(in_ready), 64'd3);
        chk("after_deq_pc0", 64'(out_pc[31:0]), 64'h8);

        // count=7 then two lanes offered: only lane 0 fits
        drive(2'b01, 32'h20, 2'd0);
        step();
        chk("c7_count", 64'(count), 64'd7);
        drive(2'b11, 32'h24, 2'd0);
        #1;
        chk("c7_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("c8_count", 64'(count), 64'd8);
        // Drain: 0x8..0x24 in order, 0x28 must not appear
        drive(2'b00, 32'h0, 2'd2);
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'h8 + 32'(i * 8);
            chk("drain_pc0", 64'(out_pc[31:0]), 64'(exp_pc));
            chk("drain_pc1", 64'(out_pc[63:32]), 64'(exp_pc + 32'd4));
            step();
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        // Wrap-around stream of 40 sequential PCs with mixed traffic
        mcount = 0;
        nxt    = 0;
        expd   = 0;
        cyc    = 0;
        while (expd < 40 && cyc < 300) begin
            en   = (cyc % 4 == 0) ? 2 : (cyc % 4 == 1) ? 1 : (cyc % 4 == 2) ? 2 : 0;
            want = (40 - nxt < en) ? 40 - nxt : en;
            rdy  = (8 - mcount >= 2) ? 2 : (8 - mcount);
            acc  = (want < rdy) ? want : rdy;
            dq   = (cyc % 3 == 0) ? 2 : (cyc % 3 == 1) ? 1 : 0;
            if (dq > mcount) dq = mcount;
            chk("wrap_count", 64'(count), 64'(mcount));
            if (dq >= 1) chk("wrap_pc0", 64'(out_pc[31:0]), 64'(32'h1000 + 32'(expd * 4)));
            if (dq == 2) chk("wrap_pc1", 64'(out_pc[63:32]), 64'(32'h1000 + 32'(expd * 4 + 4)));
            drive((want == 2) ? 2'b11 : (want == 1) ? 2'b01 : 2'b00,
                  32'h1000 + 32'(nxt * 4), 2'(dq));
            step();
            mcount = mcount + acc - dq;
            nxt    = nxt + acc;
            expd   = expd + dq;
            cyc++;
        end
        chk("wrap_total", 64'(expd), 64'd40);
        chk("wrap_end_empty", 64'(empty), 64'd1);

        // Flush with count=5 and same-cycle enqueue/dequeue
        drive(2'b11, 32'h300, 2'd0);
        step();
        drive(2'b11, 32'h308, 2'd0);
        step();
        drive(2'b01, 32'h310, 2'd0);
        step();
        chk("pre_flush_count", 64'(count), 64'd5);
        drive(2'b11, 32'h318, 2'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(2'b00, 32'h0, 2'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(empty), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-cycle with count=6
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'h400 + 32'(i * 8), 2'd0);
            step();
        end
        drive(2'b00, 32'h0, 2'd0);
        chk("pre_rst_count", 64'(count), 64'd6);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        step();
        reset_n = 1'b1;
        drive(2'b11, 32'h200, 2'd0);
        step();
        drive(2'b00, 32'h0, 2'd0);
        chk("resume_count", 64'(count), 64'd2);
        chk("resume_pc0", 64'(out_pc[31:0]), 64'h200);
        chk("resume_pc1", 64'(out_pc[63:32]), 64'h204);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
